// File: rtl/sort3_serial.sv
// Sequential three-operand sorter: one shared comparator applied over three
// compare-swap passes (0,1), (1,2), (0,1), with a valid/ready handshake on each side.
module sort3_serial #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] mid_val,
   output logic [WIDTH-1:0] min_val,
   output logic [1:0]       largest,
   output logic [1:0]       smallest,
   output logic             all_equal,
   output logic [15:0]      sort_count
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] CS01A = 3'd1;
   localparam logic [2:0] CS12  = 3'd2;
   localparam logic [2:0] CS01B = 3'd3;
   localparam logic [2:0] DONE  = 3'd4;

   // Each slot word is {value, tag}; tag occupies the two LSBs.
   logic [2:0]       state_reg, state_next;
   logic [15:0]      sort_count_reg, sort_count_next;
   logic [WIDTH+1:0] slot_reg  [3];
   logic [WIDTH+1:0] slot_next [3];
   logic [WIDTH+1:0] load_word [3];

   logic             load;
   logic             busy;
   logic             pair_hi;
   logic [1:0]       lo_idx, hi_idx;
   logic [WIDTH+1:0] lo_word, hi_word;
   logic             swap;

   assign load      = (state_reg == IDLE) && in_valid;
   assign busy      = (state_reg == CS01A) || (state_reg == CS12) || (state_reg == CS01B);
   assign pair_hi   = (state_reg == CS12);
   assign lo_idx    = pair_hi ? 2'd1 : 2'd0;
   assign hi_idx    = pair_hi ? 2'd2 : 2'd1;
   assign lo_word   = pair_hi ? slot_reg[1] : slot_reg[0];
   assign hi_word   = pair_hi ? slot_reg[2] : slot_reg[1];
   // Strict compare on values only keeps equal operands in input order.
   assign swap      = busy && (lo_word[WIDTH+1:2] > hi_word[WIDTH+1:2]);

   assign load_word[0] = {A, 2'b00};
   assign load_word[1] = {B, 2'b01};
   assign load_word[2] = {C, 2'b10};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_slot
         always_comb begin
            slot_next[gi] = slot_reg[gi];
            if (load) begin
               slot_next[gi] = load_word[gi];
            end else if (swap) begin
               if (lo_idx == 2'(gi)) slot_next[gi] = hi_word;
               if (hi_idx == 2'(gi)) slot_next[gi] = lo_word;
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) slot_reg[gi] <= '0;
            else     slot_reg[gi] <= slot_next[gi];
         end
      end
   endgenerate

   always_comb begin
      state_next      = state_reg;
      sort_count_next = sort_count_reg;
      case (state_reg)
         IDLE:    if (in_valid) state_next = CS01A;
         CS01A:   state_next = CS12;
         CS12:    state_next = CS01B;
         CS01B:   state_next = DONE;
         DONE: begin
            if (out_ready) begin
               state_next      = IDLE;
               sort_count_next = sort_count_reg + 16'd1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg      <= IDLE;
         sort_count_reg <= '0;
      end else begin
         state_reg      <= state_next;
         sort_count_reg <= sort_count_next;
      end
   end

   assign in_ready   = (state_reg == IDLE);
   assign out_valid  = (state_reg == DONE);
   assign min_val    = slot_reg[0][WIDTH+1:2];
   assign smallest   = slot_reg[0][1:0];
   assign mid_val    = slot_reg[1][WIDTH+1:2];
   assign max_val    = slot_reg[2][WIDTH+1:2];
   assign largest    = slot_reg[2][1:0];
   // Gated so the all-zero reset contents do not read as "all equal".
   assign all_equal  = out_valid && (slot_reg[0][WIDTH+1:2] == slot_reg[2][WIDTH+1:2]);
   assign sort_count = sort_count_reg;

endmodule

// File: tb/tb_sort3_serial.sv
// Directed bench for sort3_serial: hand-computed sorts, ties, backpressure,
// mid-flight reset and counter wrap.
module tb_sort3_serial;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A, B, C;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] max_val, mid_val, min_val;
   logic [1:0]  largest, smallest;
   logic        all_equal;
   logic [15:0] sort_count;

   int          vectors_applied = 0;
   int          miscompares     = 0;
   logic [15:0] exp_count       = 16'd0;

   always #5 clk = ~clk;

   sort3_serial #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .C(C),
      .out_valid(out_valid), .out_ready(out_ready),
      .max_val(max_val), .mid_val(mid_val), .min_val(min_val),
      .largest(largest), .smallest(smallest), .all_equal(all_equal),
      .sort_count(sort_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors_applied++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_result(input string tag, input logic [15:0] emax, input logic [15:0] emid,
                               input logic [15:0] emin, input logic [1:0] elg,
                               input logic [1:0] esm, input logic eeq);
      check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
      check({tag, ".max"},       32'(max_val),   32'(emax));
      check({tag, ".mid"},       32'(mid_val),   32'(emid));
      check({tag, ".min"},       32'(min_val),   32'(emin));
      check({tag, ".largest"},   32'(largest),   32'(elg));
      check({tag, ".smallest"},  32'(smallest),  32'(esm));
      check({tag, ".all_equal"}, 32'(all_equal), 32'(eeq));
   endtask

   task automatic finish_transfer(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      exp_count = exp_count + 16'd1;
      check({tag, ".count"},    32'(sort_count), 32'(exp_count));
      check({tag, ".ovalid0"},  32'(out_valid),  32'd0);
      check({tag, ".iready1"},  32'(in_ready),   32'd1);
   endtask

   // Accept a triple, confirm 3-cycle latency, check the result and transfer it.
   task automatic run_vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] emax, input logic [15:0] emid,
                          input logic [15:0] emin, input logic [1:0] elg, input logic [1:0] esm,
                          input logic eeq);
      check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      A = a; B = b; C = c; in_valid = 1'b1;
      tick();
      in_valid = 1'b0; A = 16'hDEAD; B = 16'hBEEF; C = 16'h1234;
      check({tag, ".busy"}, 32'(in_ready), 32'd0);
      tick(); tick();
      check({tag, ".early"}, 32'(out_valid), 32'd0);
      tick();
      check_result(tag, emax, emid, emin, elg, esm, eeq);
      finish_transfer(tag);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      A = 16'd1; B = 16'd2; C = 16'd3;
      tick(); tick();
      check("rst.in_ready",  32'(in_ready),   32'd1);
      check("rst.out_valid", 32'(out_valid),  32'd0);
      check("rst.count",     32'(sort_count), 32'd0);
      check("rst.vals",      {max_val, min_val}, 32'd0);
      check("rst.mid",       32'(mid_val),   32'd0);
      check("rst.idx",       {28'd0, largest, smallest}, 32'd0);
      check("rst.all_equal", 32'(all_equal), 32'd0);

      // in_valid held through reset release is taken on the first edge with rst low.
      rst = 1'b0;
      tick();
      in_valid = 1'b0;
      check("rel.accepted", 32'(in_ready), 32'd0);
      tick(); tick();
      check("rel.early", 32'(out_valid), 32'd0);
      tick();
      check_result("rel", 16'd3, 16'd2, 16'd1, 2'b10, 2'b00, 1'b0);
      finish_transfer("rel");

      run_vec("distinct", 16'd10, 16'd20, 16'd30, 16'd30, 16'd20, 16'd10, 2'b10, 2'b00, 1'b0);
      run_vec("reverse",  16'd30, 16'd20, 16'd10, 16'd30, 16'd20, 16'd10, 2'b00, 2'b10, 1'b0);
      run_vec("tie_bot",  16'd40, 16'd10, 16'd10, 16'd40, 16'd10, 16'd10, 2'b00, 2'b01, 1'b0);
      run_vec("all_eq",   16'd25, 16'd25, 16'd25, 16'd25, 16'd25, 16'd25, 2'b10, 2'b00, 1'b1);
      run_vec("tie_top",  16'd50, 16'd50, 16'd40, 16'd50, 16'd50, 16'd40, 2'b01, 2'b10, 1'b0);
      run_vec("tie_mix",  16'd5,  16'd10, 16'd5,  16'd10, 16'd5,  16'd5,  2'b01, 2'b00, 1'b0);

      // out_ready high before DONE must not transfer early.
      out_ready = 1'b1;
      A = 16'd7; B = 16'd3; C = 16'd9; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick();
      check("early_rdy.count", 32'(sort_count), 32'(exp_count));
      tick();
      check_result("early_rdy", 16'd9, 16'd7, 16'd3, 2'b10, 2'b01, 1'b0);
      tick();
      out_ready = 1'b0;
      exp_count = exp_count + 16'd1;
      check("early_rdy.count2", 32'(sort_count), 32'(exp_count));

      // Backpressure: hold DONE for 10 cycles, ignore a stray in_valid.
      A = 16'd300; B = 16'd100; C = 16'd200; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            A = 16'd1; B = 16'd1; C = 16'd1; in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         check_result($sformatf("bp%0d", i), 16'd300, 16'd200, 16'd100, 2'b00, 2'b01, 1'b0);
         check($sformatf("bp%0d.in_ready", i), 32'(in_ready), 32'd0);
         check($sformatf("bp%0d.count", i), 32'(sort_count), 32'(exp_count));
         tick();
      end
      in_valid = 1'b0;
      finish_transfer("bp");
      tick();
      check("bp.idle", 32'(in_ready), 32'd1);

      // Reset while in CS12 discards the triple.
      A = 16'd9; B = 16'd8; C = 16'd7; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      #1 rst = 1'b1;
      #1;
      check("mrst.out_valid", 32'(out_valid),  32'd0);
      check("mrst.in_ready",  32'(in_ready),   32'd1);
      check("mrst.count",     32'(sort_count), 32'd0);
      check("mrst.max",       32'(max_val),    32'd0);
      tick();
      rst = 1'b0;
      exp_count = 16'd0;
      tick();
      check("mrst.stay_idle", 32'(out_valid), 32'd0);
      run_vec("post_rst", 16'd2, 16'd9, 16'd4, 16'd9, 16'd4, 16'd2, 2'b01, 2'b00, 1'b0);

      // Counter wrap from 0xFFFF.
      force dut.sort_count_reg = 16'hFFFF;
      #1;
      release dut.sort_count_reg;
      exp_count = 16'hFFFF;
      check("wrap.pre", 32'(sort_count), 32'h0000_FFFF);
      run_vec("wrap", 16'd11, 16'd12, 16'd13, 16'd13, 16'd12, 16'd11, 2'b10, 2'b00, 1'b0);
      check("wrap.zero", 32'(sort_count), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
      $finish;
   end

endmodule
